// File: rtl/disp_msg_scheduler.sv
// Scrolling message scheduler for the 8-digit seven-segment display.
// Fetches message text from a shared synchronous ROM and paces the scroll.
module disp_msg_scheduler #(
  parameter int         STEP_DIV = 50_000_000,
  parameter int         MSG_LEN  = 16,
  parameter logic [4:0] BLANK    = 5'h1F
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  state,
  output logic [$clog2(MSG_LEN)+1:0]  rom_addr,
  input  logic [4:0]                  rom_data,
  output logic [39:0]                 window,
  output logic                        win_valid,
  output logic [1:0]                  msg_id,
  output logic                        wrap
);

  localparam int IW = $clog2(MSG_LEN);
  localparam int CW = $clog2(STEP_DIV);

  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);
  localparam logic [IW-1:0] PTR_MAX = IW'(MSG_LEN - 1);
  localparam logic [39:0]   BLANKS  = {8{BLANK}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_F,
    S_SHIFT_F,
    S_RUN,
    S_FETCH,
    S_SHIFT
  } fsm_t;

  fsm_t          fsm, fsm_n;
  logic          cur_vld, cur_vld_n;
  logic [1:0]    cur_id, cur_id_n;
  logic [IW-1:0] ptr, ptr_n, ptr_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    fill, fill_n;
  logic [39:0]   window_n;
  logic          win_valid_n;
  logic [IW+1:0] rom_addr_n;
  logic          wrap_n;

  logic          map_vld;
  logic [1:0]    map_id;
  logic          changed;

  // Map the ATM state code onto a message; unlisted codes mean idle.
  always_comb begin
    map_vld = 1'b1;
    map_id  = 2'd0;
    case (state)
      4'b0001: map_id = 2'd0;
      4'b0010: map_id = 2'd1;
      4'b1000: map_id = 2'd2;
      4'b1010: map_id = 2'd0;
      default: map_vld = 1'b0;
    endcase
  end

  assign changed = (map_vld != cur_vld) ||
                   (map_vld && (map_id != cur_id));
  assign ptr_inc = ptr + 1'b1;
  assign msg_id  = cur_id;

  // Next-state logic: restart on message change, else fill/step.
  always_comb begin
    fsm_n       = fsm;
    cur_vld_n   = cur_vld;
    cur_id_n    = cur_id;
    ptr_n       = ptr;
    cnt_n       = cnt;
    fill_n      = fill;
    window_n    = window;
    win_valid_n = win_valid;
    rom_addr_n  = rom_addr;
    wrap_n      = 1'b0;
    if (fsm == S_IDLE) begin
      window_n    = BLANKS;
      win_valid_n = 1'b0;
      if (map_vld) begin
        cur_vld_n  = 1'b1;
        cur_id_n   = map_id;
        ptr_n      = '0;
        fill_n     = 3'd0;
        cnt_n      = '0;
        rom_addr_n = {map_id, {IW{1'b0}}};
        fsm_n      = S_FETCH_F;
      end
    end else if (changed) begin
      win_valid_n = 1'b0;
      window_n    = BLANKS;
      cnt_n       = '0;
      if (!map_vld) begin
        cur_vld_n = 1'b0;
        fsm_n     = S_IDLE;
      end else begin
        cur_id_n   = map_id;
        ptr_n      = '0;
        fill_n     = 3'd0;
        rom_addr_n = {map_id, {IW{1'b0}}};
        fsm_n      = S_FETCH_F;
      end
    end else begin
      case (fsm)
        S_FETCH_F: fsm_n = S_SHIFT_F;
        S_SHIFT_F: begin
          window_n = {window[34:0], rom_data};
          ptr_n    = ptr_inc;
          wrap_n   = (ptr == PTR_MAX);
          if (fill == 3'd7) begin
            win_valid_n = 1'b1;
            fsm_n       = S_RUN;
          end else begin
            fill_n     = fill + 1'b1;
            rom_addr_n = {cur_id, ptr_inc};
            fsm_n      = S_FETCH_F;
          end
        end
        S_RUN: begin
          if (cnt == CNT_MAX) begin
            cnt_n      = '0;
            rom_addr_n = {cur_id, ptr};
            fsm_n      = S_FETCH;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_FETCH: fsm_n = S_SHIFT;
        S_SHIFT: begin
          window_n = {window[34:0], rom_data};
          ptr_n    = ptr_inc;
          wrap_n   = (ptr == PTR_MAX);
          fsm_n    = S_RUN;
        end
        default: fsm_n = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      cur_vld   <= 1'b0;
      cur_id    <= 2'd0;
      ptr       <= '0;
      cnt       <= '0;
      fill      <= 3'd0;
      window    <= BLANKS;
      win_valid <= 1'b0;
      rom_addr  <= '0;
      wrap      <= 1'b0;
    end else begin
      fsm       <= fsm_n;
      cur_vld   <= cur_vld_n;
      cur_id    <= cur_id_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      fill      <= fill_n;
      window    <= window_n;
      win_valid <= win_valid_n;
      rom_addr  <= rom_addr_n;
      wrap      <= wrap_n;
    end
  end

endmodule

// File: doc/disp_msg_scheduler.md
Name: disp_msg_scheduler

Overview:
- Sequences scrolling instruction text for the 8-digit seven-segment display.
- Maps the ATM `state` code to a message ID and fetches that message character by character from a shared synchronous message ROM.
- Paces the scroll with an internal prescaler and presents a 40-bit, 8-character window to `instruction_seven_seg_display`.
- Replaces the per-message free-running generators and the `rst1..rst4` selection scheme.

Parameters:
- STEP_DIV, 50_000_000, clk cycles per scroll step (0.5 s at 100 MHz); legal range ≥ 4.
- MSG_LEN, 16, characters per message; power of 2, ≥ 8.
- BLANK, 5'h1F, character code that drives all segments off.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- state  in  4  ATM top-level state code
- rom_addr  out  6  {msg_id[1:0], char_idx[3:0]} (char_idx width = log2(MSG_LEN))
- rom_data  in  5  character code; valid exactly 1 cycle after rom_addr is presented
- window  out  40  8 chars × 5 bits; [39:35] is the leftmost digit
- win_valid  out  1  high while window holds a fully loaded message
- msg_id  out  2  currently displayed message
- wrap  out  1  1-cycle pulse when the character pointer wraps MSG_LEN-1 → 0

Behaviour:
- Message mapping (combinational from `state`):
  - 4'b0001 → msg 0
  - 4'b0010 → msg 1
  - 4'b1000 → msg 2
  - 4'b1010 → msg 0
  - any other code → none (idle)
- Reset (rst=0, asynchronous): FSM=IDLE, window={8{BLANK}}, win_valid=0, rom_addr=0, msg_id=0, wrap=0, ptr=0, prescaler=0.
- Registers:
  - ptr: next character index to fetch.
  - cnt: prescaler.
  - fill_cnt: 0..7.
  - cur: registered mapped message (valid bit + ID).
- FSM states and transitions:
  - IDLE: window={8{BLANK}}, win_valid=0. When the mapped message becomes valid: latch cur, ptr=0, fill_cnt=0, cnt=0, go FETCH_F.
  - FETCH_F: rom_addr={cur, ptr}; go SHIFT_F.
  - SHIFT_F: window={window[34:0], rom_data}; ptr++. If fill_cnt==7, go RUN and set win_valid=1; otherwise fill_cnt++ and go FETCH_F. A fill therefore takes exactly 16 cycles.
  - RUN: cnt++. When cnt==STEP_DIV-1: cnt=0, go FETCH.
  - FETCH: rom_addr={cur, ptr}; go SHIFT.
  - SHIFT: window={window[34:0], rom_data}; ptr++; go RUN. win_valid stays 1 throughout.
- Step timing: consecutive window updates are exactly STEP_DIV+2 cycles apart.
- ptr wraps modulo MSG_LEN. wrap pulses in the same cycle ptr goes MSG_LEN-1 → 0, including during fill.
- Message change: checked every cycle in every non-IDLE state. If the mapped message differs from cur (including a change to none), abort in the next cycle:
  - win_valid=0, window={8{BLANK}}, cnt=0.
  - Go IDLE if the new message is none; otherwise latch the new cur and go FETCH_F with ptr=0.
- `state` changes between two codes that map to the same message (0001 ↔ 1010) cause no restart and no glitch.
- The ROM read issued in FETCH/FETCH_F is never lost: SHIFT always consumes it unless a message change aborts in that same cycle, in which case the data is discarded.
- Asynchronous reset mid-fill or mid-step returns immediately to reset values.
- rom_addr holds its last value outside the FETCH states.

Test Plan:
- STEP_DIV=4, ROM msg0 = chars 0..15. Release reset with state=0001 → win_valid rises 16 cycles later. Window = chars 0..7, i.e. {5'd0, 5'd1, …, 5'd7}.
- Continue in RUN → window shifts every 6 cycles to 1..8, 2..9, …. After ptr reaches 15, wrap pulses once and the window shows 9..15,0.
- Change state 0001 → 0010 mid-RUN → next cycle win_valid=0 and window=all BLANK. Refill with msg1 chars; msg_id=1 and rom_addr[5:4]=2'b01.
- Change state 0001 → 1010 → no restart; the window keeps scrolling on schedule.
- Change state to 0100 during SHIFT_F → IDLE. Window=40'hFF_FFFF_FFFF, win_valid=0; no further ROM addresses issued.
- Assert rst low mid-fill → all outputs return to reset values asynchronously. Release with state=1000 → msg2 fill starts at ptr=0.
